// File: rtl/memory_bus_pkg.sv
// Shared types and helpers for the memory-bus RAM controller and its SRAM array.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } bus_state_t;

    localparam int WORD_BYTES = 4;
    localparam int WAIT_CNT_W = 4;

    // Only naturally aligned byte, halfword and word stores are accepted.
    function automatic logic isLegalWriteMask(input logic [3:0] mask);
        logic legal;
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/memory_bus_sram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module memory_bus_sram_array
    import memory_bus_pkg::*;
#(
    parameter int WORD_ADDR_W = 13,
    parameter     INIT_FILE   = ""
) (
    input  logic                   clock,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_BYTES-1:0]  byte_we,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata
);

    localparam int DEPTH = 1 << WORD_ADDR_W;

    logic [31:0] mem_r [DEPTH];

    // Byte-lane writes; the read returns the word as it was before this edge.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_we[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/memory_bus_ram_controller.sv
// Memory-bus RAM controller: request/ready handshake, programmable wait states, write-mask checking.
// Defining MEMORY_BUS_STATS_EN adds read/write/error statistics counters and their ports.
module memory_bus_ram_controller
    import memory_bus_pkg::*;
#(
    parameter int ADDRESS_SIZE = 15,
    parameter int WAIT_STATES  = 0,
    parameter     INIT_FILE    = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    strobe,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic                    writeEnable,
    input  logic [3:0]              writeMask,
    input  logic [31:0]             dataWrite,
    output logic [31:0]             dataRead,
    output logic                    ready,
    output logic                    error
`ifdef MEMORY_BUS_STATS_EN
    ,
    output logic [31:0]             readCount,
    output logic [31:0]             writeCount,
    output logic [15:0]             errorCount
`endif
);

    localparam int WORD_ADDR_W = ADDRESS_SIZE - 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    bus_state_t              state_r, state_next_s;
    logic [WAIT_CNT_W-1:0]   cnt_r, cnt_next_s;
    logic                    accept_s;
    logic [WORD_ADDR_W-1:0]  addr_r;
    logic                    we_r;
    logic [3:0]              mask_r;
    logic [31:0]             wdata_r;
    logic                    ready_r, ready_next_s;
    logic                    error_r, error_next_s;
    logic [31:0]             data_r, data_next_s;
    logic [WORD_ADDR_W-1:0]  sram_addr_s;
    logic [WORD_BYTES-1:0]   sram_we_s;
    logic [31:0]             sram_rdata_s;
    logic                    addr_lsb_unused_s;

    assign addr_lsb_unused_s = ^address[1:0];

    // State, wait counter and registered response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {WAIT_CNT_W{1'b0}};
            ready_r <= 1'b0;
            error_r <= 1'b0;
            data_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= ready_next_s;
            error_r <= error_next_s;
            data_r  <= data_next_s;
        end
    end

    // Request capture; later changes on the bus are ignored until the next IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r  <= {WORD_ADDR_W{1'b0}};
            we_r    <= 1'b0;
            mask_r  <= 4'b0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            addr_r  <= address[ADDRESS_SIZE-1:2];
            we_r    <= writeEnable;
            mask_r  <= writeMask;
            wdata_r <= dataWrite;
        end
    end

    // Next-state and response logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        ready_next_s = 1'b0;
        error_next_s = 1'b0;
        data_next_s  = data_r;
        case (state_r)
            IDLE: begin
                if (strobe) begin
                    accept_s   = 1'b1;
                    cnt_next_s = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_next_s = ACCESS;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = WAIT;
                end
            end
            ACCESS: begin
                state_next_s = RESPOND;
                ready_next_s = 1'b1;
                error_next_s = we_r & ~isLegalWriteMask(mask_r);
                if (!we_r) begin
                    data_next_s = sram_rdata_s;
                end else begin
                    data_next_s = data_r;
                end
            end
            RESPOND: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // The array read is launched one cycle ahead so the word is ready during ACCESS
    always_comb begin
        sram_addr_s = addr_r;
        sram_we_s   = 4'b0000;
        if (state_r == IDLE) begin
            sram_addr_s = address[ADDRESS_SIZE-1:2];
        end else begin
            sram_addr_s = addr_r;
        end
        if ((state_r == ACCESS) && we_r && isLegalWriteMask(mask_r) && !reset) begin
            sram_we_s = mask_r;
        end else begin
            sram_we_s = 4'b0000;
        end
    end

    memory_bus_sram_array #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .clock   (clock),
        .addr    (sram_addr_s),
        .byte_we (sram_we_s),
        .wdata   (wdata_r),
        .rdata   (sram_rdata_s)
    );

    assign dataRead = data_r;
    assign ready    = ready_r;
    assign error    = error_r;

`ifdef MEMORY_BUS_STATS_EN
    logic [31:0] read_count_r;
    logic [31:0] write_count_r;
    logic [15:0] error_count_r;

    // Per-transaction statistics, counted once per response and wrapping at max
    always_ff @(posedge clock) begin
        if (reset) begin
            read_count_r  <= 32'd0;
            write_count_r <= 32'd0;
            error_count_r <= 16'd0;
        end else if (state_r == RESPOND) begin
            if (we_r) begin
                write_count_r <= write_count_r + 32'd1;
            end else begin
                read_count_r <= read_count_r + 32'd1;
            end
            if (error_r) begin
                error_count_r <= error_count_r + 16'd1;
            end
        end
    end

    assign readCount  = read_count_r;
    assign writeCount = write_count_r;
    assign errorCount = error_count_r;
`endif

endmodule

// File: tb/tb_memory_bus_ram_controller.sv
// Randomised self-checking bench: one controller with no wait states, one with three,
// both compared against a word-array reference model of the RAM.
module tb_memory_bus_ram_controller;

    localparam int AW = 15;
    localparam int WS [2] = '{0, 3};

    logic          clock;
    logic          reset       [2];
    logic          strobe      [2];
    logic [AW-1:0] address     [2];
    logic          writeEnable [2];
    logic [3:0]    writeMask   [2];
    logic [31:0]   dataWrite   [2];
    logic [31:0]   dataRead    [2];
    logic          ready       [2];
    logic          error       [2];
`ifdef MEMORY_BUS_STATS_EN
    logic [31:0]   readCount   [2];
    logic [31:0]   writeCount  [2];
    logic [15:0]   errorCount  [2];
`endif

    memory_bus_ram_controller #(.ADDRESS_SIZE(AW), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset[0]), .strobe(strobe[0]), .address(address[0]),
        .writeEnable(writeEnable[0]), .writeMask(writeMask[0]), .dataWrite(dataWrite[0]),
        .dataRead(dataRead[0]), .ready(ready[0]), .error(error[0])
`ifdef MEMORY_BUS_STATS_EN
        , .readCount(readCount[0]), .writeCount(writeCount[0]), .errorCount(errorCount[0])
`endif
    );

    memory_bus_ram_controller #(.ADDRESS_SIZE(AW), .WAIT_STATES(3)) dut1 (
        .clock(clock), .reset(reset[1]), .strobe(strobe[1]), .address(address[1]),
        .writeEnable(writeEnable[1]), .writeMask(writeMask[1]), .dataWrite(dataWrite[1]),
        .dataRead(dataRead[1]), .ready(ready[1]), .error(error[1])
`ifdef MEMORY_BUS_STATS_EN
        , .readCount(readCount[1]), .writeCount(writeCount[1]), .errorCount(errorCount[1])
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [2][16];
    int n_rd = 0;
    int n_wr = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit mask_ok(input logic [3:0] m);
        return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // mode 0: plain, 1: change address mid-transaction, 2: reset one cycle after acceptance
    task automatic run_txn(input int d, input logic we, input logic [AW-1:0] addr,
                           input logic [3:0] mask, input logic [31:0] data,
                           input int mode, input string tag);
        int          wi;
        int          lat;
        bit          seen;
        logic        exp_err;
        logic [31:0] exp_data;
        wi       = int'(addr[5:2]);
        exp_err  = we && !mask_ok(mask);
        exp_data = ref_mem[d][wi];
        @(posedge clock); #1;
        strobe[d] = 1'b1; writeEnable[d] = we; address[d] = addr;
        writeMask[d] = mask; dataWrite[d] = data;
        if (mode == 2) begin
            @(posedge clock); #1;
            reset[d] = 1'b1;
            @(posedge clock); #1;
            reset[d] = 1'b0; strobe[d] = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clock); #1;
                if (ready[d]) seen = 1'b1;
            end
            check_eq({tag, "_no_ready"}, 32'(seen), 32'd0);
            if (d == 0) begin
                n_rd = 0; n_wr = 0; n_err = 0;
            end
            return;
        end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (mode == 1 && k == 2) address[d] = addr + 15'h0004;
            if (ready[d]) begin
                lat = k;
                break;
            end
        end
        strobe[d] = 1'b0;
        if (lat == 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(WS[d] + 2));
        check_eq({tag, "_err"}, 32'(error[d]), 32'(exp_err));
        if (!we) check_eq({tag, "_data"}, dataRead[d], exp_data);
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) ref_mem[d][wi][8*b +: 8] = data[8*b +: 8];
            end
        end
        if (d == 0) begin
            if (we) n_wr++; else n_rd++;
            if (exp_err) n_err++;
        end
        @(posedge clock); #1;
        check_eq({tag, "_pulse"}, 32'(ready[d]), 32'd0);
    endtask

    task automatic do_reset(input int d);
        @(posedge clock); #1;
        reset[d] = 1'b1; strobe[d] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset[d] = 1'b0;
        if (d == 0) begin
            n_rd = 0; n_wr = 0; n_err = 0;
        end
    endtask

    logic [3:0] legal_masks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        logic [3:0]    m;
        logic [AW-1:0] a;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; strobe[d] = 1'b0; address[d] = '0; writeEnable[d] = 1'b0;
            writeMask[d] = 4'b0000; dataWrite[d] = 32'h0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst%0d_ready", d), 32'(ready[d]), 32'd0);
            check_eq($sformatf("rst%0d_error", d), 32'(error[d]), 32'd0);
            check_eq($sformatf("rst%0d_data", d), dataRead[d], 32'd0);
            reset[d] = 1'b0;
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                run_txn(d, 1'b1, AW'(w * 4), 4'b1111, $urandom, 0, "fill");

        run_txn(0, 1'b1, 15'h0010, 4'b1111, 32'hDEADBEEF, 0, "wr_full");
        run_txn(0, 1'b0, 15'h0010, 4'b0000, 32'h0, 0, "rd_full");
        check_eq("deadbeef", dataRead[0], 32'hDEADBEEF);
        run_txn(0, 1'b1, 15'h0010, 4'b0001, 32'h000000AA, 0, "wr_b0");
        run_txn(0, 1'b1, 15'h0012, 4'b0010, 32'h0000BB00, 0, "wr_b1");
        run_txn(0, 1'b0, 15'h0010, 4'b0000, 32'h0, 0, "rd_lane");
        check_eq("byte_lane", dataRead[0], 32'hDEADBBAA);
        run_txn(0, 1'b1, 15'h0020, 4'b1111, 32'h12345678, 0, "wr_base");
        run_txn(0, 1'b1, 15'h0020, 4'b0101, 32'hFFFFFFFF, 0, "wr_ill");
        run_txn(0, 1'b1, 15'h0020, 4'b0000, 32'hFFFFFFFF, 0, "wr_zero");
        run_txn(0, 1'b0, 15'h0020, 4'b0000, 32'h0, 0, "rd_ill");
        check_eq("illegal_kept", dataRead[0], 32'h12345678);

        run_txn(1, 1'b0, 15'h0010, 4'b0000, 32'h0, 1, "ws3_rd_chg");
        run_txn(1, 1'b1, 15'h0030, 4'b1111, 32'hA5A5A5A5, 2, "ws3_rst");
        run_txn(1, 1'b0, 15'h0030, 4'b0000, 32'h0, 0, "ws3_rd_old");

        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 3) != 0) m = legal_masks[$urandom_range(0, 6)];
            else m = 4'($urandom_range(0, 15));
            a = AW'({$urandom_range(0, 15), 2'($urandom_range(0, 3))});
            run_txn(i % 2, 1'($urandom_range(0, 1)), a, m, $urandom, 0, "rand");
        end

`ifdef MEMORY_BUS_STATS_EN
        do_reset(0);
        for (int i = 0; i < 3; i++) run_txn(0, 1'b0, AW'(i * 4), 4'b0000, 32'h0, 0, "st_rd");
        run_txn(0, 1'b1, 15'h0004, 4'b0011, $urandom, 0, "st_wr");
        run_txn(0, 1'b1, 15'h0008, 4'b1000, $urandom, 0, "st_wr");
        run_txn(0, 1'b1, 15'h000C, 4'b0110, $urandom, 0, "st_ill");
        check_eq("read_count", readCount[0], 32'(n_rd));
        check_eq("write_count", writeCount[0], 32'(n_wr));
        check_eq("error_count", 32'(errorCount[0]), 32'(n_err));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
